// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CPU-bus arbiter.
// The optional slave-ack timeout is enabled with `CPU_BUS_ARB_TIMEOUT_EN.
package cpu_bus_pkg;

    localparam int          CPU_BUS_ADDR_W = 32;
    localparam logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF;

    typedef struct packed {
        logic [CPU_BUS_ADDR_W-1:0] address;
        logic [31:0]               wdata;
        logic [3:0]                wmask;
    } cpu_bus_req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } cpu_bus_arb_state_e;

endpackage

// File: rtl/cpu_bus_rr_picker.sv
// Combinational round-robin picker: first pending requester after i_ptr, wrapping.
module cpu_bus_rr_picker #(
    parameter  int NUM_MASTERS = 2,
    localparam int IDX_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic [NUM_MASTERS-1:0] i_pending,
    input  logic [IDX_W-1:0]       i_ptr,
    output logic [IDX_W-1:0]       o_idx,
    output logic                   o_valid
);

    // Walk from the farthest candidate back to ptr+1 so the nearest pending one wins.
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            int j;
            j       = (int'(i_ptr) + k) % NUM_MASTERS;
            o_idx   = i_pending[IDX_W'(j)] ? IDX_W'(j) : o_idx;
            o_valid = o_valid | i_pending[IDX_W'(j)];
        end
    end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Round-robin arbiter sharing one CPU-bus slave port between NUM_MASTERS requesters.
// Define `CPU_BUS_ARB_TIMEOUT_EN to force a DEAD_BEEF/error response when the slave never acks.
module cpu_bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_MASTERS-1:0]        m_request,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_address,
    input  logic [NUM_MASTERS*32-1:0]     m_wdata,
    input  logic [NUM_MASTERS*4-1:0]      m_wmask,
    output logic [NUM_MASTERS-1:0]        m_ack,
    output logic [31:0]                   m_rdata,
    output logic [NUM_MASTERS-1:0]        m_error,
    output logic                          s_request,
    output logic [ADDR_W-1:0]             s_address,
    output logic [31:0]                   s_wdata,
    output logic [3:0]                    s_wmask,
    input  logic                          s_ack,
    input  logic [31:0]                   s_rdata,
    output logic                          busy
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    if (NUM_MASTERS < 2 || NUM_MASTERS > 4 || ADDR_W > CPU_BUS_ADDR_W ||
        TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
        $error("cpu_bus_arbiter: unsupported parameter set");
    end

    cpu_bus_arb_state_e     r_state;
    logic [NUM_MASTERS-1:0] r_pending;
    logic [IDX_W-1:0]       r_ptr;
    logic [IDX_W-1:0]       r_winner;
    cpu_bus_req_t           r_slot [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] r_m_ack;
    logic [31:0]            r_m_rdata;
    logic                   r_s_request;
    logic [ADDR_W-1:0]      r_s_address;
    logic [31:0]            r_s_wdata;
    logic [3:0]             r_s_wmask;
    logic                   r_busy;
    logic [IDX_W-1:0]       w_grant_idx;
    logic                   w_grant_valid;
    logic [NUM_MASTERS-1:0] w_release;

    cpu_bus_rr_picker #(.NUM_MASTERS(NUM_MASTERS)) u_picker (
        .i_pending (r_pending),
        .i_ptr     (r_ptr),
        .o_idx     (w_grant_idx),
        .o_valid   (w_grant_valid)
    );

    // One-hot of the master whose pending bit retires this cycle.
    always_comb begin
        w_release = '0;
        if (r_state == RESP) begin
            w_release = NUM_MASTERS'(1) << r_winner;
        end else begin
            w_release = '0;
        end
    end

    // Request capture; a retiring master may re-request in its ack cycle, otherwise repeats are dropped.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pending <= '0;
            for (int i = 0; i < NUM_MASTERS; i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (m_request[i] && (!r_pending[i] || w_release[i])) begin
                    r_pending[i]         <= 1'b1;
                    r_slot[i].address    <= CPU_BUS_ADDR_W'(m_address[i*ADDR_W +: ADDR_W]);
                    r_slot[i].wdata      <= m_wdata[i*32 +: 32];
                    r_slot[i].wmask      <= m_wmask[i*4 +: 4];
                end else if (w_release[i]) begin
                    r_pending[i] <= 1'b0;
                end
            end
        end
    end

`ifdef CPU_BUS_ARB_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT > 255) ? 16 : 8;

    logic [TMO_W-1:0]       r_tmo_cnt;
    logic [NUM_MASTERS-1:0] r_m_error;

    assign m_error = r_m_error;
`else
    assign m_error = '0;
`endif

    // Transaction FSM: grant, single-cycle slave request, wait for ack, single-cycle master ack.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_ptr       <= IDX_W'(NUM_MASTERS - 1);
            r_winner    <= '0;
            r_m_ack     <= '0;
            r_m_rdata   <= 32'h0000_0000;
            r_s_request <= 1'b0;
            r_s_address <= '0;
            r_s_wdata   <= 32'h0000_0000;
            r_s_wmask   <= 4'h0;
            r_busy      <= 1'b0;
`ifdef CPU_BUS_ARB_TIMEOUT_EN
            r_tmo_cnt   <= '0;
            r_m_error   <= '0;
`endif
        end else begin
            r_s_request <= 1'b0;
            r_m_ack     <= '0;
`ifdef CPU_BUS_ARB_TIMEOUT_EN
            r_m_error   <= '0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_winner    <= w_grant_idx;
                        r_ptr       <= w_grant_idx;
                        r_s_address <= r_slot[w_grant_idx].address[ADDR_W-1:0];
                        r_s_wdata   <= r_slot[w_grant_idx].wdata;
                        r_s_wmask   <= r_slot[w_grant_idx].wmask;
                        r_s_request <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_state <= WAIT;
`ifdef CPU_BUS_ARB_TIMEOUT_EN
                    r_tmo_cnt <= '0;
`endif
                end
                WAIT: begin
                    // A real ack wins over a timeout expiring in the same cycle.
                    if (s_ack) begin
                        r_m_rdata <= s_rdata;
                        r_m_ack   <= NUM_MASTERS'(1) << r_winner;
                        r_busy    <= 1'b0;
                        r_state   <= RESP;
                    end
`ifdef CPU_BUS_ARB_TIMEOUT_EN
                    else if (r_tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                        r_m_rdata <= TIMEOUT_RDATA;
                        r_m_ack   <= NUM_MASTERS'(1) << r_winner;
                        r_m_error <= NUM_MASTERS'(1) << r_winner;
                        r_busy    <= 1'b0;
                        r_state   <= RESP;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    end
`endif
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign m_ack     = r_m_ack;
    assign m_rdata   = r_m_rdata;
    assign s_request = r_s_request;
    assign s_address = r_s_address;
    assign s_wdata   = r_s_wdata;
    assign s_wmask   = r_s_wmask;
    assign busy      = r_busy;

endmodule
